// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
//
// Purpose:
//    Bundles the writeback requester handshake and the register-file write
//    port into one interface. The arbiter connects through the slave modport.
//    The requesters and register-file side, or a testbench, connect through
//    the master modport.
//
// Signals:
//    Req_Valid       NREQ          request i holds a write
//    Req_Addr        NREQ*ADDR_W   request i destination, slice [i*ADDR_W +: ADDR_W]
//    Req_Data        NREQ*DATA_W   request i data, slice [i*DATA_W +: DATA_W]
//    Req_Ready       NREQ          one-hot grant back to the requesters
//    Flush           1             discard any staged write
//    RegWrite        1             register-file write enable
//    Write_Register  ADDR_W        register-file write index
//    Write_Data      DATA_W        register-file write data
//    Pending_Mask    2**ADDR_W     register whose write is staged but not yet committed
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
   parameter int NREQ   = 2,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [NREQ-1:0]        Req_Valid;
   logic [NREQ*ADDR_W-1:0] Req_Addr;
   logic [NREQ*DATA_W-1:0] Req_Data;
   logic [NREQ-1:0]        Req_Ready;
   logic                   Flush;
   logic                   RegWrite;
   logic [ADDR_W-1:0]      Write_Register;
   logic [DATA_W-1:0]      Write_Data;
   logic [2**ADDR_W-1:0]   Pending_Mask;

   modport master (
      output Req_Valid, Req_Addr, Req_Data, Flush,
      input  Req_Ready, RegWrite, Write_Register, Write_Data, Pending_Mask
   );

   modport slave (
      input  Req_Valid, Req_Addr, Req_Data, Flush,
      output Req_Ready, RegWrite, Write_Register, Write_Data, Pending_Mask
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//    Shares the single register-file write port among NREQ writeback
//    requesters. Arbitration is round-robin and uses valid/ready handshakes.
//    The winning request is staged for one cycle and is then driven onto the
//    write port. Writes to register 0 complete their handshake but never
//    raise RegWrite. Pending_Mask shows which register is staged, so that
//    decode can stall reads of that register.
//
// Ports:
//    Clock     in   rising-edge clock
//    Reset_n   in   asynchronous, active-low reset
//    bus       slave modport of regfile_write_arbiter_if (requests, grants,
//              Flush, register-file write port, Pending_Mask)
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
   parameter int NREQ   = 2,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input logic                    Clock,
   input logic                    Reset_n,
   regfile_write_arbiter_if.slave bus
);

   localparam int PTR_W = $clog2(NREQ);
   localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NREQ - 1);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t             state;
   state_t             next_state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   winner;
   logic               found;
   logic               handshake;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_data;
   logic [ADDR_W-1:0]  staged_addr;
   logic [DATA_W-1:0]  staged_data;

   // The round-robin search is split into two passes. The first pass covers
   // requesters at or above rr_ptr. The second pass wraps around to the ones
   // below it. This avoids a modulo on a variable index and works for any
   // NREQ from 2 to 4.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && (i >= int'(rr_ptr)) && bus.Req_Valid[i]) begin
            found    = 1'b1;
            winner   = PTR_W'(i);
            win_addr = bus.Req_Addr[i*ADDR_W +: ADDR_W];
            win_data = bus.Req_Data[i*DATA_W +: DATA_W];
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && (i < int'(rr_ptr)) && bus.Req_Valid[i]) begin
            found    = 1'b1;
            winner   = PTR_W'(i);
            win_addr = bus.Req_Addr[i*ADDR_W +: ADDR_W];
            win_data = bus.Req_Data[i*DATA_W +: DATA_W];
         end
      end
   end

   // A grant is suppressed during Flush and while reset is held. Because of
   // that, a raised Ready bit always means a handshake completes at the next
   // edge.
   always_comb begin
      handshake     = found && !bus.Flush && Reset_n;
      bus.Req_Ready = '0;
      if (handshake) begin
         bus.Req_Ready[winner] = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. Flush always returns the FSM to IDLE. Otherwise every
   // handshake produces exactly one ISSUE cycle, so back-to-back grants keep
   // the FSM in ISSUE.
   always_comb begin
      next_state = IDLE;
      if (bus.Flush) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    next_state = handshake ? ISSUE : IDLE;
            ISSUE:   next_state = handshake ? ISSUE : IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Stage the winner and advance the round-robin pointer past it. Both are
   // updated only on a handshake. The staged values also serve as the held
   // write-port values while the FSM is idle.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         staged_addr <= '0;
         staged_data <= '0;
         rr_ptr      <= '0;
      end else if (handshake) begin
         staged_addr <= win_addr;
         staged_data <= win_data;
         rr_ptr      <= (winner == LAST_REQ) ? '0 : winner + 1'b1;
      end
   end

   // Write-port drive. A Flush during ISSUE also masks RegWrite in that same
   // cycle, so the discarded write never reaches the register file. Register
   // 0 is never written and never reported as pending.
   always_comb begin
      bus.RegWrite       = 1'b0;
      bus.Pending_Mask   = '0;
      bus.Write_Register = staged_addr;
      bus.Write_Data     = staged_data;
      if ((state == ISSUE) && (staged_addr != '0)) begin
         bus.Pending_Mask[staged_addr] = 1'b1;
         bus.RegWrite                  = !bus.Flush;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Purpose:
//    Directed testbench for regfile_write_arbiter with NREQ=2, DATA_W=32 and
//    ADDR_W=5. Each expected commit is queued when its grant is checked. A
//    separate monitor pops the queue whenever RegWrite is high and keeps a
//    register-file model up to date.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

   localparam int NREQ   = 2;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic Clock   = 1'b0;
   logic Reset_n = 1'b0;

   // 100 MHz free-running clock.
   always #5 Clock = ~Clock;

   regfile_write_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

   regfile_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int                cyc;
   } exp_t;

   exp_t              exp_q[$];
   int                checks   = 0;
   int                failures = 0;
   int                cyc      = 0;
   logic [DATA_W-1:0] rf_model [2**ADDR_W];

   task automatic check_val(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Count rising edges so that each queued commit can name the cycle in
   // which it is due.
   always @(posedge Clock) begin
      cyc <= cyc + 1;
   end

   // Monitor. Every cycle in which RegWrite is high must match the oldest
   // queued commit in address, data and cycle. The register-file model
   // captures the write in the same cycle.
   always @(negedge Clock) begin
      exp_t e;
      if (Reset_n && (bus.RegWrite === 1'b1)) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_write actual=r%0d expected=no_write", bus.Write_Register);
         end else begin
            e = exp_q.pop_front();
            check_val("commit_addr", 64'(bus.Write_Register), 64'(e.addr));
            check_val("commit_data", 64'(bus.Write_Data), 64'(e.data));
            check_val("commit_cycle", 64'(cyc), 64'(e.cyc));
         end
         rf_model[bus.Write_Register] = bus.Write_Data;
      end
   end

   task automatic apply_stimulus(input logic [NREQ-1:0] valid,
                                 input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                                 input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                                 input logic flush);
      bus.Req_Valid = valid;
      bus.Req_Addr  = {a1, a0};
      bus.Req_Data  = {d1, d0};
      bus.Flush     = flush;
   endtask

   task automatic next_cycle();
      @(posedge Clock);
      #1;
   endtask

   task automatic mid_cycle();
      @(negedge Clock);
   endtask

   // Check the grant in this cycle. When push is set, queue the commit that
   // is expected in the following cycle.
   task automatic check_grant(input string name, input logic [NREQ-1:0] exp_ready, input logic push,
                              input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      check_val(name, 64'(bus.Req_Ready), 64'(exp_ready));
      if (push) exp_q.push_back('{addr: addr, data: data, cyc: cyc + 1});
   endtask

   task automatic check_output(input string name, input logic exp_we, input logic [ADDR_W-1:0] exp_reg,
                               input logic [DATA_W-1:0] exp_data, input logic [2**ADDR_W-1:0] exp_pend);
      check_val({name, "_regwrite"}, 64'(bus.RegWrite), 64'(exp_we));
      check_val({name, "_wreg"}, 64'(bus.Write_Register), 64'(exp_reg));
      check_val({name, "_wdata"}, 64'(bus.Write_Data), 64'(exp_data));
      check_val({name, "_pending"}, 64'(bus.Pending_Mask), 64'(exp_pend));
   endtask

   // Watchdog so that the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus.
   initial begin
      for (int r = 0; r < 2**ADDR_W; r++) rf_model[r] = '0;

      // Reset, with a request already valid. Ready must stay low.
      apply_stimulus(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0);
      repeat (2) @(posedge Clock);
      mid_cycle();
      check_output("reset", 1'b0, 5'd0, 32'h0, 32'h0);
      check_val("reset_ready", 64'(bus.Req_Ready), 64'h0);

      next_cycle();
      Reset_n = 1'b1;
      apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
      mid_cycle();
      check_grant("idle_ready", 2'b00, 1'b0, 5'd0, 32'h0);

      // Single write: r5 <= DEADBEEF. rr_ptr moves to 1.
      next_cycle();
      apply_stimulus(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0);
      mid_cycle();
      check_grant("single_ready", 2'b01, 1'b1, 5'd5, 32'hDEADBEEF);
      next_cycle();
      apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
      mid_cycle();
      check_output("single_commit", 1'b1, 5'd5, 32'hDEADBEEF, 32'h20);

      // Requester 1 alone: r3. rr_ptr wraps back to 0.
      next_cycle();
      apply_stimulus(2'b10, 5'd0, 5'd3, 32'h0, 32'h33, 1'b0);
      mid_cycle();
      check_grant("req1_ready", 2'b10, 1'b1, 5'd3, 32'h33);

      // Round-robin. Both requesters stay valid, and each presents fresh data
      // once accepted. Expected grants are 0,1,0,1 with RegWrite high
      // throughout.
      for (int k = 0; k < 4; k++) begin
         logic [DATA_W-1:0] d0;
         logic [DATA_W-1:0] d1;
         d0 = 32'h1001 + 32'((k + 1) / 2);
         d1 = 32'h2001 + 32'(k / 2);
         next_cycle();
         apply_stimulus(2'b11, 5'd1, 5'd2, d0, d1, 1'b0);
         mid_cycle();
         if (k % 2 == 0) check_grant("rr_grant0", 2'b01, 1'b1, 5'd1, d0);
         else            check_grant("rr_grant1", 2'b10, 1'b1, 5'd2, d1);
         check_val("rr_regwrite", 64'(bus.RegWrite), 64'h1);
      end
      next_cycle();
      apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
      mid_cycle();
      check_output("rr_tail", 1'b1, 5'd2, 32'h2002, 32'h4);

      // A write to r0 gets its handshake but is never committed.
      next_cycle();
      apply_stimulus(2'b01, 5'd0, 5'd0, 32'h1234, 32'h0, 1'b0);
      mid_cycle();
      check_grant("r0_ready", 2'b01, 1'b0, 5'd0, 32'h1234);
      next_cycle();
      apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
      mid_cycle();
      check_output("r0_drop", 1'b0, 5'd0, 32'h1234, 32'h0);

      // Flush. The r7 write is staged and then discarded. The next request
      // is held through the flush and accepted afterwards.
      next_cycle();
      apply_stimulus(2'b01, 5'd7, 5'd0, 32'h7777, 32'h0, 1'b0);
      mid_cycle();
      check_grant("flush_pre_ready", 2'b01, 1'b0, 5'd7, 32'h7777);
      next_cycle();
      apply_stimulus(2'b01, 5'd8, 5'd0, 32'h8888, 32'h0, 1'b1);
      mid_cycle();
      check_grant("flush_ready", 2'b00, 1'b0, 5'd0, 32'h0);
      check_val("flush_regwrite", 64'(bus.RegWrite), 64'h0);
      next_cycle();
      apply_stimulus(2'b01, 5'd8, 5'd0, 32'h8888, 32'h0, 1'b0);
      mid_cycle();
      check_val("flush_after_regwrite", 64'(bus.RegWrite), 64'h0);
      check_grant("flush_retry", 2'b01, 1'b1, 5'd8, 32'h8888);
      next_cycle();
      apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
      mid_cycle();
      check_output("flush_retry_commit", 1'b1, 5'd8, 32'h8888, 32'h100);
      check_val("flush_r7_model", 64'(rf_model[7]), 64'h0);

      // Same address with rr_ptr=1. B is committed first and A second, so
      // r9 ends up holding A.
      next_cycle();
      apply_stimulus(2'b11, 5'd9, 5'd9, 32'hAAAA0009, 32'hBBBB0009, 1'b0);
      mid_cycle();
      check_grant("same_first", 2'b10, 1'b1, 5'd9, 32'hBBBB0009);
      next_cycle();
      apply_stimulus(2'b01, 5'd9, 5'd0, 32'hAAAA0009, 32'h0, 1'b0);
      mid_cycle();
      check_grant("same_second", 2'b01, 1'b1, 5'd9, 32'hAAAA0009);
      next_cycle();
      apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
      mid_cycle();
      next_cycle();
      mid_cycle();
      check_val("same_final_r9", 64'(rf_model[9]), 64'hAAAA0009);

      // Reset while r4 is staged. The write is lost at once, and rr_ptr
      // returns to 0, which it would not do by itself here.
      next_cycle();
      apply_stimulus(2'b01, 5'd4, 5'd0, 32'h4444, 32'h0, 1'b0);
      mid_cycle();
      check_grant("pre_reset_ready", 2'b01, 1'b0, 5'd4, 32'h4444);
      next_cycle();
      Reset_n = 1'b0;
      #1;
      check_val("reset_mid_regwrite", 64'(bus.RegWrite), 64'h0);
      check_val("reset_mid_pending", 64'(bus.Pending_Mask), 64'h0);
      check_val("reset_mid_ready", 64'(bus.Req_Ready), 64'h0);
      next_cycle();
      Reset_n = 1'b1;
      apply_stimulus(2'b11, 5'd10, 5'd11, 32'hAAAA1010, 32'hBBBB1111, 1'b0);
      mid_cycle();
      check_grant("post_reset_ptr", 2'b01, 1'b1, 5'd10, 32'hAAAA1010);
      next_cycle();
      apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
      repeat (3) next_cycle();
      mid_cycle();

      check_val("queue_empty", 64'(exp_q.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
